// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM state
// encoding and the access-size helper.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_D  = 3'b011;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;
  localparam logic [2:0] F3_WU = 3'b110;

  typedef logic [1:0] lsu_state_t;

  localparam lsu_state_t ST_IDLE = 2'd0;
  localparam lsu_state_t ST_RD   = 2'd1;
  localparam lsu_state_t ST_WR   = 2'd2;
  localparam lsu_state_t ST_RESP = 2'd3;

  // Access size in bytes; 111 falls into the doubleword slot and is faulted elsewhere.
  function automatic logic [3:0] size_bytes(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   return 4'd1;
      2'b01:   return 4'd2;
      2'b10:   return 4'd4;
      default: return 4'd8;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational data steering: sub-word store merge into the read doubleword
// and sign/zero extension of load results.
module lsu_align
  import lsu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] merged,
  output logic [XLEN-1:0] extended
);

  function automatic logic [XLEN-1:0] extend(input logic [2:0] f3,
                                             input logic [XLEN-1:0] d);
    case (f3)
      F3_B:    return {{(XLEN-8){d[7]}}, d[7:0]};
      F3_H:    return {{(XLEN-16){d[15]}}, d[15:0]};
      F3_W:    return {{(XLEN-32){d[31]}}, d[31:0]};
      F3_BU:   return {{(XLEN-8){1'b0}}, d[7:0]};
      F3_HU:   return {{(XLEN-16){1'b0}}, d[15:0]};
      F3_WU:   return {{(XLEN-32){1'b0}}, d[31:0]};
      default: return d;
    endcase
  endfunction

  logic [3:0] nbytes;

  // Low N bytes come from the store data; a doubleword store takes all of wdata.
  always_comb begin
    nbytes = size_bytes(funct3);
    merged = rdata;
    for (int k = 0; k < XLEN/8; k++) begin
      if (k < int'(nbytes)) merged[8*k +: 8] = wdata[8*k +: 8];
    end
  end

  assign extended = extend(funct3, rdata);

endmodule

// File: rtl/load_store_unit.sv
// MEM-stage initiator for the 64-bit byte-addressed data memory. One request
// at a time; sub-word stores are performed as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int MEM_BYTES = 512,
  parameter int XLEN      = 64
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_we,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] Mem_Addr,
  output logic [XLEN-1:0] Write_Data,
  output logic            MemWrite,
  output logic            MemRead,
  input  logic [XLEN-1:0] Read_Data
);

  lsu_state_t      state, state_nxt;
  logic [XLEN-1:0] addr_q, wdata_q, rdata_q;
  logic [2:0]      funct3_q;
  logic            we_q, err_q;
  logic            accept, fault;
  logic [2:0]      align_mask;
  logic [XLEN-1:0] merged, extended;

  assign accept     = req_valid && req_ready;
  assign align_mask = 3'(size_bytes(req_funct3) - 4'd1);

  always_comb begin
    fault = (req_funct3 == 3'b111)
         || (req_we && req_funct3[2])
         || ((req_addr[2:0] & align_mask) != 3'd0)
         || (req_addr > XLEN'(MEM_BYTES - 8));
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          if (fault)                                state_nxt = ST_RESP;
          else if (req_we && req_funct3 == F3_D)    state_nxt = ST_WR;
          else                                      state_nxt = ST_RD;
        end
      end
      ST_RD:   state_nxt = we_q ? ST_WR : ST_RESP;
      ST_WR:   state_nxt = ST_RESP;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Control state: reset returns to IDLE at once, which drops MemWrite mid-cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
      err_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) err_q <= fault;
    end
  end

  // Request and read-data capture; outputs are gated by state so no reset is needed.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_q   <= req_addr;
      wdata_q  <= req_wdata;
      funct3_q <= req_funct3;
      we_q     <= req_we;
    end
    if (state == ST_RD) rdata_q <= Read_Data;
  end

  lsu_align #(.XLEN(XLEN)) u_align (
    .funct3   (funct3_q),
    .wdata    (wdata_q),
    .rdata    (rdata_q),
    .merged   (merged),
    .extended (extended)
  );

  assign req_ready  = (state == ST_IDLE) && !reset;
  assign MemRead    = (state == ST_RD);
  assign MemWrite   = (state == ST_WR);
  assign Mem_Addr   = (state == ST_RD || state == ST_WR) ? addr_q : '0;
  assign Write_Data = (state == ST_WR) ? merged : '0;

  assign resp_valid = (state == ST_RESP);
  assign resp_err   = (state == ST_RESP) && err_q;
  assign resp_rdata = (state == ST_RESP && !err_q && !we_q) ? extended : '0;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed vector table, reset-abort sequence and
// random traffic against a byte-array reference model.
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int MEM_BYTES = 512;
  localparam int XLEN      = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        req_ready, resp_valid, resp_err, MemWrite, MemRead;
  logic [63:0] resp_rdata, Mem_Addr, Write_Data, Read_Data;

  always #5 clk = ~clk;

  load_store_unit #(.MEM_BYTES(MEM_BYTES), .XLEN(XLEN)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .Mem_Addr   (Mem_Addr),
    .Write_Data (Write_Data),
    .MemWrite   (MemWrite),
    .MemRead    (MemRead),
    .Read_Data  (Read_Data)
  );

  // Data memory: writes 8 bytes at Mem_Addr; pokes used only for preloading.
  logic [7:0]  dmem    [0:MEM_BYTES-1];
  logic [7:0]  ref_mem [0:MEM_BYTES-1];
  logic        poke_en = 1'b0;
  logic [8:0]  poke_addr = 9'd0;
  logic [63:0] poke_data = 64'd0;

  always @(posedge clk) begin
    if (poke_en) begin
      for (int k = 0; k < 8; k++) dmem[int'(poke_addr) + k] <= poke_data[8*k +: 8];
    end else if (MemWrite && Mem_Addr <= 64'(MEM_BYTES - 8)) begin
      for (int k = 0; k < 8; k++) dmem[int'(Mem_Addr[8:0]) + k] <= Write_Data[8*k +: 8];
    end
  end

  always_comb begin
    Read_Data = 64'd0;
    if (Mem_Addr <= 64'(MEM_BYTES - 8)) begin
      for (int k = 0; k < 8; k++) Read_Data[8*k +: 8] = dmem[int'(Mem_Addr[8:0]) + k];
    end
  end

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: byte array, only the N addressed bytes change on a store.
  function automatic void ref_access(input logic we, input logic [2:0] f3,
                                     input logic [63:0] addr, input logic [63:0] wdata,
                                     output logic [63:0] rdata, output logic err,
                                     output int lat);
    int n;
    n = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : (f3[1:0] == 2'd2) ? 4 : 8;
    err = (f3 == 3'b111) || (we && f3[2]) || ((addr % 64'(n)) != 64'd0)
       || (addr > 64'(MEM_BYTES - 8));
    rdata = 64'd0;
    if (err) begin
      lat = 1;
    end else if (!we) begin
      for (int k = 0; k < n; k++) rdata[8*k +: 8] = ref_mem[int'(addr) + k];
      if (!f3[2] && n < 8 && rdata[8*n-1]) rdata = rdata | (~64'd0 << (8*n));
      lat = 2;
    end else begin
      for (int k = 0; k < n; k++) ref_mem[int'(addr) + k] = wdata[8*k +: 8];
      lat = (n == 8) ? 2 : 3;
    end
  endfunction

  task automatic poke(input int addr, input logic [63:0] data);
    poke_en   = 1'b1;
    poke_addr = 9'(addr);
    poke_data = data;
    for (int k = 0; k < 8; k++) ref_mem[addr + k] = data[8*k +: 8];
    @(posedge clk);
    #1 poke_en = 1'b0;
    @(negedge clk);
  endtask

  // Issues one request at a negedge and follows it to its response.
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat, output int nrd, output int nwr,
                        output logic [63:0] wr_addr, output logic [63:0] wr_data);
    int guard, busy_ready, both;
    logic got;
    guard = 0;
    while (!req_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 20) check("ready_timeout", 64'(req_ready), 64'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    lat = 0; nrd = 0; nwr = 0; busy_ready = 0; both = 0; got = 1'b0;
    rdata = 64'd0; err = 1'b0; wr_addr = 64'd0; wr_data = 64'd0;
    while (!got && lat < 8) begin
      @(negedge clk);
      lat++;
      if (MemRead) nrd++;
      if (MemWrite) begin
        nwr++;
        wr_addr = Mem_Addr;
        wr_data = Write_Data;
      end
      if (MemRead && MemWrite) both++;
      if (req_ready) busy_ready++;
      if (resp_valid) begin
        got   = 1'b1;
        rdata = resp_rdata;
        err   = resp_err;
      end
    end
    if (!got) lat = 99;
    @(negedge clk);
    check("resp_single_pulse", 64'(resp_valid), 64'd0);
    check("ready_after_resp", 64'(req_ready), 64'd1);
    check("busy_not_ready", 64'(busy_ready), 64'd0);
    check("rd_wr_exclusive", 64'(both), 64'd0);
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    logic        chk_wr;
    logic [63:0] exp_wr;
  } vec_t;

  vec_t vt[$];

  initial begin
    logic [63:0] rd, wa, wd, mr;
    logic        er, me;
    int          lt, nr, nw, ml, seen, mism;
    logic        we;
    logic [2:0]  f3;
    logic [63:0] addr, wdata;
    int          n;

    vt.push_back('{1'b0, F3_D,   64'd256, 64'd0,    64'h5,                  1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_B,   64'd264, 64'hFF,   64'd0,                  1'b0, 3, 1'b1, 64'h00000000000000FF});
    vt.push_back('{1'b0, F3_B,   64'd264, 64'd0,    64'hFFFFFFFFFFFFFFFF,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_BU,  64'd264, 64'd0,    64'hFF,                 1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_H,   64'd258, 64'h1234, 64'd0,                  1'b0, 3, 1'b1, 64'h00FF000000001234});
    vt.push_back('{1'b0, F3_D,   64'd256, 64'd0,    64'h0000000012340005,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_W,   64'd257, 64'd0,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_D,   64'd512, 64'd0,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_D,   64'd504, 64'd0,    64'd0,                  1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_D,   64'd272, 64'h80000000FFFF8001, 64'd0,      1'b0, 2, 1'b1, 64'h80000000FFFF8001});
    vt.push_back('{1'b0, F3_H,   64'd272, 64'd0,    64'hFFFFFFFFFFFF8001,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_WU,  64'd272, 64'd0,    64'h00000000FFFF8001,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_W,   64'd272, 64'd0,    64'hFFFFFFFFFFFF8001,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_HU,  64'd274, 64'd0,    64'h000000000000FFFF,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_B,   64'd279, 64'd0,    64'hFFFFFFFFFFFFFF80,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_W,   64'd260, 64'h11223344DEADBEEF, 64'd0,      1'b0, 3, 1'b1, 64'h000000FFDEADBEEF});
    vt.push_back('{1'b0, F3_D,   64'd256, 64'd0,    64'hDEADBEEF12340005,   1'b0, 2, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_B,   64'd511, 64'h7,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_H,   64'd263, 64'h7,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b0, 3'b111, 64'd256, 64'd0,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_BU,  64'd256, 64'h7,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b1, F3_D,   64'd505, 64'h7,    64'd0,                  1'b1, 1, 1'b0, 64'd0});
    vt.push_back('{1'b0, F3_D,   64'd264, 64'd0,    64'hFF,                 1'b0, 2, 1'b0, 64'd0});

    // Reset state
    @(negedge clk);
    check("rst_req_ready", 64'(req_ready), 64'd0);
    check("rst_resp_valid", 64'(resp_valid), 64'd0);
    check("rst_resp_rdata", resp_rdata, 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_memread", 64'(MemRead), 64'd0);
    check("rst_memwrite", 64'(MemWrite), 64'd0);
    check("rst_mem_addr", Mem_Addr, 64'd0);
    check("rst_write_data", Write_Data, 64'd0);

    for (int a = 0; a < MEM_BYTES; a += 8) poke(a, 64'd0);
    poke(256, 64'h5);
    poke(264, 64'h9);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", 64'(req_ready), 64'd1);

    // Directed vectors
    foreach (vt[i]) begin
      ref_access(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, mr, me, ml);
      do_req(vt[i].we, vt[i].f3, vt[i].addr, vt[i].wdata, rd, er, lt, nr, nw, wa, wd);
      check($sformatf("vec%0d_rdata", i), rd, vt[i].exp_rdata);
      check($sformatf("vec%0d_err", i), 64'(er), 64'(vt[i].exp_err));
      check($sformatf("vec%0d_latency", i), 64'(lt), 64'(vt[i].exp_lat));
      check($sformatf("vec%0d_memread_cycles", i), 64'(nr),
            (!vt[i].exp_err && !(vt[i].we && vt[i].f3 == F3_D)) ? 64'd1 : 64'd0);
      check($sformatf("vec%0d_memwrite_cycles", i), 64'(nw),
            (!vt[i].exp_err && vt[i].we) ? 64'd1 : 64'd0);
      if (vt[i].chk_wr) begin
        check($sformatf("vec%0d_wr_addr", i), wa, vt[i].addr);
        check($sformatf("vec%0d_wr_data", i), wd, vt[i].exp_wr);
      end
    end

    // Reset asserted during the WR cycle of a sub-word store
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = F3_B; req_addr = 64'd280; req_wdata = 64'hAA;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    check("abort_rd_phase", 64'(MemRead), 64'd1);
    @(negedge clk);
    check("abort_wr_phase", 64'(MemWrite), 64'd1);
    check("abort_wr_addr", Mem_Addr, 64'd280);
    reset = 1'b1;
    #1;
    check("abort_memwrite_drop", 64'(MemWrite), 64'd0);
    check("abort_ready_in_reset", 64'(req_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    seen = 0;
    for (int c = 0; c < 4; c++) begin
      #1 if (resp_valid) seen++;
      @(negedge clk);
    end
    check("abort_no_resp", 64'(seen), 64'd0);
    check("abort_ready_after", 64'(req_ready), 64'd1);
    check("abort_mem_unchanged", 64'(dmem[280]), 64'(ref_mem[280]));

    // Random back-to-back traffic
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0) f3 = 3'($urandom_range(0, 7));
      else f3 = we ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 6));
      n = 1 << f3[1:0];
      if ($urandom_range(0, 9) == 0) addr = 64'($urandom_range(0, 520));
      else addr = 64'(($urandom_range(240, 320) / n) * n);
      wdata = {$urandom, $urandom};
      ref_access(we, f3, addr, wdata, mr, me, ml);
      do_req(we, f3, addr, wdata, rd, er, lt, nr, nw, wa, wd);
      check($sformatf("rnd%0d_rdata", i), rd, mr);
      check($sformatf("rnd%0d_err", i), 64'(er), 64'(me));
      check($sformatf("rnd%0d_latency", i), 64'(lt), 64'(ml));
    end

    mism = 0;
    for (int a = 0; a < MEM_BYTES; a++) if (dmem[a] !== ref_mem[a]) mism++;
    check("final_memory_image", 64'(mism), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
